// File: rtl/memoredf_pkg.sv
// Shared definitions for the EDF scheduler: FSM state encoding, default
// sizing constants and a helper for index widths.
package memoredf_pkg;

   localparam int DEFAULT_NUMBER_OF_QUEUES = 4;
   localparam int DEFAULT_REGISTER_SIZE    = 32;

   // Scheduler control states; the encoding is kept fixed so that
   // existing debug tooling that decodes the raw state bits keeps working.
   typedef enum logic [1:0] {
      ST_IDLE       = 2'd0,
      ST_ISSUE      = 2'd1,
      ST_WAIT_VALID = 2'd2,
      ST_WAIT_DONE  = 2'd3
   } state_e;

   // Width of a queue index; a single-queue build still gets a 1-bit id.
   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/edf_scheduler_if.sv
// Bundle of the scheduler's queueing-domain and serializer handshake signals.
// The master side is the scheduler, the slave side is the queue/serializer.
interface edf_scheduler_if
   import memoredf_pkg::*;
#(
   parameter int NUMBER_OF_QUEUES = DEFAULT_NUMBER_OF_QUEUES,
   parameter int REGISTER_SIZE    = DEFAULT_REGISTER_SIZE
) ();

   localparam int ID_W = id_width(NUMBER_OF_QUEUES);

   logic [NUMBER_OF_QUEUES-1:0][REGISTER_SIZE-1:0] queues_period;
   logic [NUMBER_OF_QUEUES-1:0]                    empty;
   logic                                           queues_to_serializer_valid;
   logic                                           serializer_done;
   logic                                           scheduler_to_queues_ready;
   logic [ID_W-1:0]                                core_id;
   logic                                           busy;

   modport master (
      input  queues_period,
      input  empty,
      input  queues_to_serializer_valid,
      input  serializer_done,
      output scheduler_to_queues_ready,
      output core_id,
      output busy
   );

   modport slave (
      output queues_period,
      output empty,
      output queues_to_serializer_valid,
      output serializer_done,
      input  scheduler_to_queues_ready,
      input  core_id,
      input  busy
   );

endinterface

// File: rtl/edf_min_finder.sv
// Combinational argmin over the deadline counters of the pending queues.
// Ties resolve to the lowest index because only a strictly smaller value
// displaces the current best while scanning upward.
module edf_min_finder
   import memoredf_pkg::*;
#(
   parameter int NUMBER_OF_QUEUES = DEFAULT_NUMBER_OF_QUEUES,
   parameter int REGISTER_SIZE    = DEFAULT_REGISTER_SIZE,
   localparam int ID_W            = id_width(NUMBER_OF_QUEUES)
) (
   input  logic [NUMBER_OF_QUEUES-1:0][REGISTER_SIZE-1:0] counters_i,
   input  logic [NUMBER_OF_QUEUES-1:0]                    valid_i,
   output logic [ID_W-1:0]                                index_o,
   output logic                                           any_valid_o
);

   logic [REGISTER_SIZE-1:0] best_value;

   // Linear scan keeping the smallest counter seen among valid entries.
   always_comb begin
      index_o     = '0;
      any_valid_o = 1'b0;
      best_value  = '0;
      for (int i = 0; i < NUMBER_OF_QUEUES; i++) begin
         if (valid_i[i] && (!any_valid_o || (counters_i[i] < best_value))) begin
            any_valid_o = 1'b1;
            best_value  = counters_i[i];
            index_o     = ID_W'(i);
         end
      end
   end

endmodule

// File: rtl/edf_scheduler.sv
// Earliest-deadline-first scheduler. Each queue owns a deadline counter that
// sits at its period while the queue is empty and counts down while packets
// wait. When idle, the pending queue with the smallest counter is chosen,
// popped with a single ready pulse, and the scheduler then waits for the
// serializer to accept and finish that packet before choosing again.
module edf_scheduler
   import memoredf_pkg::*;
#(
   parameter int NUMBER_OF_QUEUES = DEFAULT_NUMBER_OF_QUEUES,
   parameter int REGISTER_SIZE    = DEFAULT_REGISTER_SIZE
) (
   input  logic           clock,
   input  logic           reset,
   edf_scheduler_if.master bus
);

   localparam int ID_W = id_width(NUMBER_OF_QUEUES);

   state_e                                         state_q, state_d;
   logic [ID_W-1:0]                                core_id_q, core_id_d;
   logic [NUMBER_OF_QUEUES-1:0][REGISTER_SIZE-1:0] deadline_q, deadline_d;

   logic [NUMBER_OF_QUEUES-1:0] pending_mask;
   logic [ID_W-1:0]             winner;
   logic                        any_pending;

   assign pending_mask = ~bus.empty;

   edf_min_finder #(
      .NUMBER_OF_QUEUES (NUMBER_OF_QUEUES),
      .REGISTER_SIZE    (REGISTER_SIZE)
   ) u_min_finder (
      .counters_i  (deadline_q),
      .valid_i     (pending_mask),
      .index_o     (winner),
      .any_valid_o (any_pending)
   );

   // Control flow: choose in IDLE, pop in ISSUE, then track the serializer.
   // The winner is captured only on the IDLE->ISSUE transition so later
   // emptiness changes cannot disturb the queue already being served.
   always_comb begin
      state_d   = state_q;
      core_id_d = core_id_q;
      case (state_q)
         ST_IDLE: begin
            if (any_pending) begin
               state_d   = ST_ISSUE;
               core_id_d = winner;
            end
         end
         ST_ISSUE: begin
            state_d = ST_WAIT_VALID;
         end
         ST_WAIT_VALID: begin
            if (bus.queues_to_serializer_valid) begin
               state_d = ST_WAIT_DONE;
            end
         end
         ST_WAIT_DONE: begin
            if (bus.serializer_done) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Deadline counter update: the served queue restarts its deadline in the
   // ISSUE cycle, empty queues track their period, and waiting queues count
   // down towards zero without wrapping.
   always_comb begin
      deadline_d = deadline_q;
      for (int i = 0; i < NUMBER_OF_QUEUES; i++) begin
         if ((state_q == ST_ISSUE) && (core_id_q == ID_W'(i))) begin
            deadline_d[i] = bus.queues_period[i];
         end else if (bus.empty[i]) begin
            deadline_d[i] = bus.queues_period[i];
         end else if (deadline_q[i] != '0) begin
            deadline_d[i] = deadline_q[i] - REGISTER_SIZE'(1);
         end else begin
            deadline_d[i] = '0;
         end
      end
   end

   // Control registers; reset abandons any transaction in progress.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         core_id_q <= '0;
      end else begin
         state_q   <= state_d;
         core_id_q <= core_id_d;
      end
   end

   // Deadline registers; reset restarts every queue at its full period.
   always_ff @(posedge clock) begin
      if (reset) begin
         deadline_q <= bus.queues_period;
      end else begin
         deadline_q <= deadline_d;
      end
   end

   // The pop request is a decode of ISSUE, masked by reset so a reset that
   // lands on the ISSUE cycle cannot leak a request downstream.
   assign bus.scheduler_to_queues_ready = (state_q == ST_ISSUE) && !reset;
   assign bus.core_id                   = core_id_q;
   assign bus.busy                      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_edf_scheduler.sv
// Directed bench for edf_scheduler. Stimulus sequences push the expected
// core_id of every pop request into a queue; an independent monitor pops and
// compares on each ready pulse and also checks the spacing between pulses.
module tb_edf_scheduler;
   import memoredf_pkg::*;

   localparam int NQ = 4;
   localparam int RS = 32;

   logic clock = 1'b0;
   logic reset = 1'b1;

   edf_scheduler_if #(.NUMBER_OF_QUEUES(NQ), .REGISTER_SIZE(RS)) bus ();

   edf_scheduler #(.NUMBER_OF_QUEUES(NQ), .REGISTER_SIZE(RS)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   int tests = 0;
   int fails = 0;
   int exp_q[$];
   int exp_id;
   int cyc = 0;
   int last_pulse = 0;
   bit seen_pulse = 1'b0;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string name, input longint act, input longint req);
      tests++;
      if (act != req) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   // Scoreboard monitor: every ready pulse must be expected and carry the
   // expected core_id, and pulses must be separated by at least 2 low cycles.
   always @(negedge clock) begin
      if (bus.scheduler_to_queues_ready === 1'b1) begin
         if (seen_pulse) check("ready_gap_at_least_2", longint'((cyc - last_pulse - 1) >= 2), 1);
         seen_pulse = 1'b1;
         last_pulse = cyc;
         if (exp_q.size() == 0) begin
            check("unexpected_ready_pulse", 1, 0);
         end else begin
            exp_id = exp_q.pop_front();
            check("core_id_on_pulse", longint'(bus.core_id), exp_id);
         end
      end
   end

   task automatic set_periods(input int p0, input int p1, input int p2, input int p3);
      bus.queues_period[0] = RS'(p0);
      bus.queues_period[1] = RS'(p1);
      bus.queues_period[2] = RS'(p2);
      bus.queues_period[3] = RS'(p3);
   endtask

   // Called at a negedge; returns at the negedge where ready is high.
   task automatic wait_ready(input string name, output int waited);
      waited = 0;
      while ((bus.scheduler_to_queues_ready !== 1'b1) && (waited < 400)) begin
         @(negedge clock);
         waited++;
      end
      if (bus.scheduler_to_queues_ready !== 1'b1) check({name, "_ready_timeout"}, 0, 1);
   endtask

   // From the ready negedge: apply the post-pop emptiness, pulse valid, then
   // pulse done after done_delay cycles. Returns at a negedge in IDLE.
   task automatic finish_txn(input logic [NQ-1:0] empty_after, input int done_delay);
      bus.empty = empty_after;
      @(negedge clock);
      bus.queues_to_serializer_valid = 1'b1;
      @(negedge clock);
      bus.queues_to_serializer_valid = 1'b0;
      repeat (done_delay) @(negedge clock);
      bus.serializer_done = 1'b1;
      @(negedge clock);
      bus.serializer_done = 1'b0;
   endtask

   task automatic serve(input string name, input int id, input logic [NQ-1:0] empty_after,
                        input int done_delay);
      int w;
      exp_q.push_back(id);
      wait_ready(name, w);
      finish_txn(empty_after, done_delay);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, got %0d, expected 0 pending", exp_q.size());
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      bus.empty                      = '1;
      bus.queues_to_serializer_valid = 1'b0;
      bus.serializer_done            = 1'b0;
      set_periods(100, 40, 70, 10);

      // Reset state
      reset = 1'b1;
      repeat (3) @(negedge clock);
      check("reset_busy", bus.busy, 0);
      check("reset_core_id", bus.core_id, 0);
      check("reset_ready", bus.scheduler_to_queues_ready, 0);
      reset = 1'b0;
      repeat (2) @(negedge clock);
      check("idle_busy_when_all_empty", bus.busy, 0);

      // Single pending queue: pulse appears one cycle after the decision
      bus.empty = 4'b1101;
      exp_q.push_back(1);
      wait_ready("single_q1", w);
      check("single_q1_latency", w, 1);
      check("single_q1_busy_in_issue", bus.busy, 1);
      finish_txn(4'b1111, 2);
      check("single_q1_idle_after_done", bus.busy, 0);

      // All four pending, each drained on service: EDF order 3,1,2,0
      repeat (2) @(negedge clock);
      bus.empty = 4'b0000;
      serve("order_a", 3, 4'b1000, 1);
      serve("order_b", 1, 4'b1010, 1);
      serve("order_c", 2, 4'b1110, 1);
      serve("order_d", 0, 4'b1111, 1);

      // Equal periods: lowest index wins, its reload lets queue 2 go next
      set_periods(50, 50, 50, 50);
      repeat (2) @(negedge clock);
      bus.empty = 4'b1010;
      serve("tie_first", 0, 4'b1010, 1);
      serve("tie_second", 2, 4'b1111, 1);

      // serializer_done during WAIT_VALID is ignored
      set_periods(100, 40, 70, 10);
      repeat (2) @(negedge clock);
      bus.empty = 4'b1110;
      exp_q.push_back(0);
      wait_ready("early_done", w);
      bus.empty = 4'b1111;
      @(negedge clock);
      bus.serializer_done = 1'b1;
      @(negedge clock);
      bus.serializer_done = 1'b0;
      check("early_done_still_busy", bus.busy, 1);
      bus.queues_to_serializer_valid = 1'b1;
      @(negedge clock);
      bus.queues_to_serializer_valid = 1'b0;
      check("early_done_busy_after_valid", bus.busy, 1);
      repeat (3) @(negedge clock);
      check("early_done_waits_second_done", bus.busy, 1);
      bus.serializer_done = 1'b1;
      @(negedge clock);
      bus.serializer_done = 1'b0;
      check("early_done_idle_after_second_done", bus.busy, 0);

      // Counter saturation: queue 1 waits ~300 cycles, must stay at 0 and
      // beat queue 2 whose counter is small but non-zero
      set_periods(100, 40, 5, 100);
      repeat (2) @(negedge clock);
      bus.empty = 4'b1101;
      exp_q.push_back(1);
      wait_ready("sat_first", w);
      @(negedge clock);
      bus.queues_to_serializer_valid = 1'b1;
      @(negedge clock);
      bus.queues_to_serializer_valid = 1'b0;
      repeat (300) @(negedge clock);
      bus.empty = 4'b1001;
      bus.serializer_done = 1'b1;
      @(negedge clock);
      bus.serializer_done = 1'b0;
      serve("sat_q1_wins", 1, 4'b1011, 1);
      serve("sat_q2_next", 2, 4'b1111, 1);

      // Reset in WAIT_VALID aborts the transaction
      set_periods(100, 40, 70, 10);
      repeat (2) @(negedge clock);
      bus.empty = 4'b1011;
      exp_q.push_back(2);
      wait_ready("abort", w);
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      check("abort_busy", bus.busy, 0);
      check("abort_core_id", bus.core_id, 0);
      check("abort_ready", bus.scheduler_to_queues_ready, 0);
      reset = 1'b0;
      serve("after_abort", 2, 4'b1111, 1);

      repeat (4) @(negedge clock);
      check("scoreboard_drained", exp_q.size(), 0);
      check("final_idle", bus.busy, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
